// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the EX stage and the multiply/divide sequencer.
// The master drives issues and MTHI/MTLO writes; the slave reports busy/done and HI/LO.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             we_hi;
    logic             we_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, we_hi, we_lo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, we_hi, we_lo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: magnitude conversion, WIDTH
// shift-add or restoring-divide steps, sign fix-up, then a single HI/LO commit.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    muldiv_sequencer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   raw_a_q, raw_a_d;
    // Multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // Multiply: {product_hi, multiplier/product_lo}; divide: {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed, rem_fixed;

    always_comb begin
        is_signed = ~bus.op[0];
        a_mag = (is_signed && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
        b_mag = (is_signed && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Remainder stays below the divisor, so the 33-bit trial difference is exact.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

        prod_fixed = negq_q ? -acc_q : acc_q;
        quot_fixed = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fixed  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        div_zero_d = div_zero_q;
        raw_a_d    = raw_a_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    is_div_d   = bus.op[1];
                    negq_d     = is_signed & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
                    negr_d     = is_signed & bus.operand_a[WIDTH-1];
                    div_zero_d = bus.op[1] && (bus.operand_b == '0);
                    raw_a_d    = bus.operand_a;
                    opnd_d     = bus.op[1] ? b_mag : a_mag;
                    acc_d      = {{WIDTH{1'b0}}, bus.op[1] ? a_mag : b_mag};
                    cnt_d      = '0;
                    state_d    = S_RUN;
                end else begin
                    // MTHI/MTLO only land when no issue competes for the cycle.
                    if (bus.we_hi) hi_d = bus.wdata;
                    if (bus.we_lo) lo_d = bus.wdata;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end else if (div_zero_q) begin
                    hi_d = raw_a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fixed;
                    lo_d = quot_fixed;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            div_zero_q <= 1'b0;
            raw_a_q    <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            div_zero_q <= div_zero_d;
            raw_a_q    <= raw_a_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a latency/arithmetic reference model checked
// every cycle, plus hand-computed HI/LO expectations for each directed operation.
module tb_muldiv_sequencer;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_sequencer_if bus_if ();

    muldiv_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Arithmetic reference: MIPS semantics computed directly in 64-bit integers.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        res = '0;
        case (op)
            OP_MULT:  begin q = sa * sb; res = q; end
            OP_MULTU: begin p = ua * ub; res = p; end
            default: begin
                if (b == 32'h0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    p = ua / ub;
                    ua = ua % ub;
                    res = {ua[31:0], p[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Cycle model: an issue sets 33 cycles of busy, the last edge commits and pulses done.
    int          m_remaining;
    logic [31:0] m_hi, m_lo;
    logic        m_done;
    logic [63:0] m_pending;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_remaining <= 0;
            m_hi        <= '0;
            m_lo        <= '0;
            m_done      <= 1'b0;
            m_pending   <= '0;
        end else if (m_remaining > 0) begin
            m_remaining <= m_remaining - 1;
            m_done      <= (m_remaining == 1);
            if (m_remaining == 1) begin
                m_hi <= m_pending[63:32];
                m_lo <= m_pending[31:0];
            end
        end else begin
            m_done <= 1'b0;
            if (bus_if.start) begin
                m_pending   <= ref_result(bus_if.op, bus_if.operand_a, bus_if.operand_b);
                m_remaining <= 33;
            end else begin
                if (bus_if.we_hi) m_hi <= bus_if.wdata;
                if (bus_if.we_lo) m_lo <= bus_if.wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_busy", {63'h0, bus_if.busy}, {63'h0, m_remaining > 0});
            chk("model_done", {63'h0, bus_if.done}, {63'h0, m_done});
            chk("model_hi", {32'h0, bus_if.hi}, {32'h0, m_hi});
            chk("model_lo", {32'h0, bus_if.lo}, {32'h0, m_lo});
        end
    end

    // Entered at a falling edge; returns at the falling edge right after the issue edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_if.start     = 1'b1;
        bus_if.op        = op;
        bus_if.operand_a = a;
        bus_if.operand_b = b;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus_if.busy) busy_cycles++;
            if (bus_if.done) break;
            @(negedge clk);
        end
        chk("done_seen", {63'h0, bus_if.done}, 64'h1);
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, output int busy_cycles);
        issue(op, a, b);
        wait_done(busy_cycles);
        chk({name, "_hi"}, {32'h0, bus_if.hi}, {32'h0, exp_hi});
        chk({name, "_lo"}, {32'h0, bus_if.lo}, {32'h0, exp_lo});
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d",
                 name, op, a, b, bus_if.hi, bus_if.lo, busy_cycles);
    endtask

    initial begin
        int n;
        bus_if.start     = 1'b0;
        bus_if.op        = 2'b00;
        bus_if.operand_a = '0;
        bus_if.operand_b = '0;
        bus_if.we_hi     = 1'b0;
        bus_if.we_lo     = 1'b0;
        bus_if.wdata     = '0;

        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {63'h0, bus_if.busy}, 64'h0);
        chk("reset_done", {63'h0, bus_if.done}, 64'h0);
        chk("reset_hi", {32'h0, bus_if.hi}, 64'h0);
        chk("reset_lo", {32'h0, bus_if.lo}, 64'h0);

        run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, n);
        chk("multu_busy_cycles", 64'(n), 64'd33);
        // Back-to-back: each issue is driven on the done cycle, sampled at E34.
        run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, n);
        run("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, n);
        run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, n);
        chk("div_busy_cycles", 64'(n), 64'd33);
        run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'hE, n);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, n);
        run("divu_zero", OP_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, n);
        chk("divu_zero_busy_cycles", 64'(n), 64'd33);
        run("div_zero_signed", OP_DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, n);

        // New issue plus MTHI while busy must not disturb the running DIVU.
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus_if.start     = 1'b1;
        bus_if.op        = OP_MULTU;
        bus_if.operand_a = 32'hFFFF_FFFF;
        bus_if.operand_b = 32'hFFFF_FFFF;
        bus_if.we_hi     = 1'b1;
        bus_if.wdata     = 32'hDEAD;
        @(negedge clk);
        chk("busy_hi_hold", {32'h0, bus_if.hi}, 64'hFFFF_FFFB);
        chk("busy_lo_hold", {32'h0, bus_if.lo}, 64'hFFFF_FFFF);
        bus_if.start = 1'b0;
        bus_if.we_hi = 1'b0;
        wait_done(n);
        chk("busy_ignore_hi", {32'h0, bus_if.hi}, 64'd2);
        chk("busy_ignore_lo", {32'h0, bus_if.lo}, 64'hE);
        $display("busy_ignore -> hi=%h lo=%h", bus_if.hi, bus_if.lo);

        bus_if.we_lo = 1'b1;
        bus_if.wdata = 32'hBEEF;
        @(negedge clk);
        bus_if.we_lo = 1'b0;
        chk("mtlo_lo", {32'h0, bus_if.lo}, 64'hBEEF);
        chk("mtlo_hi_kept", {32'h0, bus_if.hi}, 64'd2);
        $display("mtlo wdata=0000beef -> hi=%h lo=%h", bus_if.hi, bus_if.lo);

        bus_if.we_hi = 1'b1;
        bus_if.we_lo = 1'b1;
        bus_if.wdata = 32'h1357;
        @(negedge clk);
        bus_if.we_hi = 1'b0;
        bus_if.we_lo = 1'b0;
        chk("mthi_mtlo_hi", {32'h0, bus_if.hi}, 64'h1357);
        chk("mthi_mtlo_lo", {32'h0, bus_if.lo}, 64'h1357);
        $display("mthi+mtlo wdata=00001357 -> hi=%h lo=%h", bus_if.hi, bus_if.lo);

        // start and MTHI in the same IDLE cycle: the write is dropped.
        bus_if.we_hi = 1'b1;
        bus_if.wdata = 32'hDEAD;
        issue(OP_MULTU, 32'd5, 32'd6);
        bus_if.we_hi = 1'b0;
        chk("start_wins_hi", {32'h0, bus_if.hi}, 64'h1357);
        wait_done(n);
        chk("start_wins_res_hi", {32'h0, bus_if.hi}, 64'h0);
        chk("start_wins_res_lo", {32'h0, bus_if.lo}, 64'd30);
        $display("start_wins -> hi=%h lo=%h", bus_if.hi, bus_if.lo);

        // Asynchronous reset in the middle of a DIV.
        issue(OP_DIV, 32'h1000, 32'd3);
        repeat (8) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_busy", {63'h0, bus_if.busy}, 64'h0);
        chk("rst_mid_done", {63'h0, bus_if.done}, 64'h0);
        chk("rst_mid_hi", {32'h0, bus_if.hi}, 64'h0);
        chk("rst_mid_lo", {32'h0, bus_if.lo}, 64'h0);
        $display("async reset mid-div -> busy=%0b hi=%h lo=%h", bus_if.busy, bus_if.hi, bus_if.lo);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        run("post_reset_multu", OP_MULTU, 32'd5, 32'd6, 32'h0, 32'd30, n);
        chk("post_reset_busy_cycles", 64'(n), 64'd33);
        @(negedge clk);
        chk("post_done_low", {63'h0, bus_if.done}, 64'h0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multi-cycle multiply/divide sequencer owning the architectural HI/LO registers of the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU issues from the EX stage and converts signed operands to magnitudes. It runs a 32-step shift-add or restoring-divide core, applies sign correction, and commits HI/LO. While the operation is in flight it holds `busy` high so hazard logic can stall dependent MFHI/MFLO and further issues.

## Interface
- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  issue strobe; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `operand_a`  in  WIDTH  rs value: multiplicand or dividend.
- `operand_b`  in  WIDTH  rt value: multiplier or divisor.
- `we_hi`  in  1  MTHI write enable.
- `we_lo`  in  1  MTLO write enable.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle pulse when HI/LO commit.
- `hi`  out  WIDTH  architectural HI.
- `lo`  out  WIDTH  architectural LO.

## Operation
- States are IDLE, RUN and FIX.
- **IDLE.**
  - On `start`, latch `op`, |a| and |b|. Magnitudes apply only to signed ops; unsigned ops latch raw values.
  - Also latch `neg_q = a[31]^b[31]` and `neg_r = a[31]`, both forced to 0 for unsigned ops.
  - Clear the step counter and go to RUN.
- **RUN.** One iteration per cycle on internal accumulators. The counter increments; at count 31 the iteration completes and the state moves to FIX.
  - Multiply: 64-bit shift-add of the magnitudes.
  - Divide: restoring division. Shift {rem,quot} left, trial-subtract the divisor, set the quotient bit when the result is non-negative.
- **FIX.**
  - Multiply: negate the 64-bit product if `neg_q`, then HI = product[63:32] and LO = product[31:0].
  - Divide: LO = quotient, negated if `neg_q`; HI = remainder, negated if `neg_r`.
  - Commit HI/LO, pulse `done`, return to IDLE.
- **Divisor zero.** Takes the full latency. Result is LO = 0xFFFFFFFF and HI = `operand_a` as latched, independent of signedness.
- **Signed overflow.** 0x80000000 / −1 yields LO = 0x80000000, HI = 0. This falls out of the magnitude arithmetic and needs no special case.
- **Operand stability.** Operands and `op` are latched at issue; input changes during RUN/FIX are ignored.
- **HI/LO visibility.** `hi`/`lo` keep their previous values until the FIX commit. Internal accumulators are never visible on the outputs.
- **MTHI/MTLO.** Writes apply at the clock edge only in IDLE and are ignored while busy. `we_hi` and `we_lo` may both be asserted in the same cycle; both registers then take `wdata`.
- **Simultaneous events.** If `start` and `we_hi`/`we_lo` arrive together in IDLE, `start` wins and the write is dropped. `start` while busy is ignored; upstream must stall on `busy`.
- **Reset.** Asynchronous and valid at any point, including mid-operation. State → IDLE, counter = 0, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, accumulators = 0. No partial result is committed.

## Timing
- `start` is sampled at edge E0.
- `busy` rises after E0 and falls after E33, so it is high for 33 cycles.
- RUN covers edges E1–E32, one iteration per edge; FIX commits at E33.
- `done` is registered: high for exactly the cycle after E33. `hi`/`lo` show the new values in that same cycle.
- The next `start` is accepted at E34, which gives back-to-back issue with a 34-cycle period.
- Total issue-to-result latency is 33 cycles for every op and operand value, with no early termination.
- MTHI/MTLO in IDLE are visible on `hi`/`lo` one cycle after the write edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles HI = 0xFFFFFFFE, LO = 0x00000001, `done` pulses once, `busy` high for exactly 33 cycles.
- MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 100 / 7 → LO = 0xE, HI = 2; DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- DIVU 0x1234 / 0 → LO = 0xFFFFFFFF, HI = 0x1234 after 33 cycles.
- While busy, apply `start` with new operands and MTHI 0xDEAD → no effect; the result equals the original op; `hi`/`lo` are unchanged until commit. MTLO 0xBEEF in IDLE → `lo` = 0xBEEF next cycle.
- Assert `rst` at cycle 10 of a DIV → `busy`, `done`, `hi` and `lo` all go to 0 immediately. A new MULTU 5 × 6 then yields LO = 30, HI = 0 with normal latency.
